// File: rtl/iter_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iter_controller_pkg
//  Description : Shared state encodings and constants for the iterative
//                datapath controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package iter_controller_pkg;

    // Width of the multiply-phase latency counter (MULT_LAT legal 1..15)
    localparam int LAT_W = 4;

    // Controller state encodings, 3 bits; 3'd7 is unused and treated as illegal
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_I    = 3'd1,
        ST_LOAD_INIT = 3'd2,
        ST_MULT      = 3'd3,
        ST_STORE     = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_counter
//  Description : Saturating iteration counter with synchronous clear and
//                increment, asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_counter #(
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [ITER_W-1:0] count
);

    // Clear has priority; increments stop at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ITER_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/iter_controller.sv
`default_nettype none
// ============================================================================
//  Module      : iter_controller
//  Description : Sequencer for the iterative datapath. Loads inputs and
//                initial values, then loops multiply -> store -> update until
//                convergence, iteration limit or abort. Outputs are registered
//                and decoded from the next state, so they track the state
//                register exactly (Moore behaviour).
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_controller
    import iter_controller_pkg::*;
#(
    parameter int ITER_W   = 8,
    parameter int MULT_LAT = 1     // legal 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              conv,
    input  logic [ITER_W-1:0] max_iter,
    output logic              ldI,
    output logic              ldInit,
    output logic              ldM,
    output logic              ldRes,
    output logic              ldA,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MULT_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ITER_W:0]   cnt_plus1;
    logic              limit_hit;
    logic              cnt_clear;
    logic              cnt_inc;

    // One extra bit so a saturated counter can never alias onto the limit
    assign cnt_plus1 = {1'b0, iter_cnt} + (ITER_W + 1)'(1);
    assign limit_hit = (max_iter != '0) && (cnt_plus1 == {1'b0, max_iter});

    // An aborted LOAD_INIT/UPDATE must leave the count untouched
    assign cnt_clear = (state == ST_LOAD_INIT) && !abort;
    assign cnt_inc   = (state == ST_UPDATE)    && !abort;

    iter_counter #(
        .ITER_W (ITER_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (iter_cnt)
    );

    // Next-state decode; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:      state_nxt = start ? ST_LOAD_I : ST_IDLE;
            ST_LOAD_I:    state_nxt = ST_LOAD_INIT;
            ST_LOAD_INIT: state_nxt = ST_MULT;
            ST_MULT:      state_nxt = (lat_cnt == '0) ? ST_STORE : ST_MULT;
            ST_STORE:     state_nxt = ST_UPDATE;
            ST_UPDATE:    state_nxt = (conv || limit_hit) ? ST_FINISH : ST_MULT;
            ST_FINISH:    state_nxt = start ? ST_LOAD_I : ST_FINISH;
            default:      state_nxt = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register, latency counter, timeout flag and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            timeout <= 1'b0;
            ldI     <= 1'b0;
            ldInit  <= 1'b0;
            ldM     <= 1'b0;
            ldRes   <= 1'b0;
            ldA     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;

            // Reload on every entry into MULT, count down while inside it
            if ((state_nxt == ST_MULT) && (state != ST_MULT)) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == ST_MULT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (abort && (state != ST_IDLE)) begin
                timeout <= 1'b0;
            end else if (state == ST_LOAD_INIT) begin
                timeout <= 1'b0;
            end else if (state == ST_UPDATE) begin
                // Convergence wins over the limit in the same update
                timeout <= !conv && limit_hit;
            end

            ldI    <= (state_nxt == ST_LOAD_I);
            ldInit <= (state_nxt == ST_LOAD_INIT);
            ldM    <= (state_nxt == ST_MULT);
            ldRes  <= (state_nxt == ST_STORE);
            ldA    <= (state_nxt == ST_UPDATE);
            busy   <= (state_nxt == ST_LOAD_I)    || (state_nxt == ST_LOAD_INIT) ||
                      (state_nxt == ST_MULT)      || (state_nxt == ST_STORE)     ||
                      (state_nxt == ST_UPDATE);
            done   <= (state_nxt == ST_FINISH);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_controller
//  Description : Self-checking bench for iter_controller. Two instances:
//                dut0 (ITER_W=2, MULT_LAT=1) and dut1 (ITER_W=8, MULT_LAT=3).
//                Expected outputs come from the cycle schedule implied by the
//                latency rules (arithmetic on cycle index).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_controller;

    logic       clk;
    logic       rst_n;

    logic       start0, abort0, conv0;
    logic [1:0] max0;
    logic       ldI0, ldInit0, ldM0, ldRes0, ldA0, busy0, done0, tmo0;
    logic [1:0] cnt0;

    logic       start1, abort1, conv1;
    logic [7:0] max1;
    logic       ldI1, ldInit1, ldM1, ldRes1, ldA1, busy1, done1, tmo1;
    logic [7:0] cnt1;

    logic [6:0] code0, code1;
    assign code0 = {ldI0, ldInit0, ldM0, ldRes0, ldA0, busy0, done0};
    assign code1 = {ldI1, ldInit1, ldM1, ldRes1, ldA1, busy1, done1};

    int checks   = 0;
    int failures = 0;
    int prev_cnt [2];
    int prev_tmo [2];

    iter_controller #(.ITER_W(2), .MULT_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .conv(conv0),
        .max_iter(max0), .ldI(ldI0), .ldInit(ldInit0), .ldM(ldM0), .ldRes(ldRes0),
        .ldA(ldA0), .busy(busy0), .done(done0), .timeout(tmo0), .iter_cnt(cnt0)
    );

    iter_controller #(.ITER_W(8), .MULT_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .conv(conv1),
        .max_iter(max1), .ldI(ldI1), .ldInit(ldInit1), .ldM(ldM1), .ldRes(ldRes1),
        .ldA(ldA1), .busy(busy1), .done(done1), .timeout(tmo1), .iter_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic a, input logic cv, input int mx);
        if (d == 0) begin
            start0 = s; abort0 = a; conv0 = cv; max0 = mx[1:0];
        end else begin
            start1 = s; abort1 = a; conv1 = cv; max1 = mx[7:0];
        end
    endtask

    function automatic logic [6:0] get_code(input int d);
        return (d == 0) ? code0 : code1;
    endfunction

    function automatic int get_cnt(input int d);
        return (d == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    function automatic int get_tmo(input int d);
        return (d == 0) ? int'(tmo0) : int'(tmo1);
    endfunction

    // One run: d selects instance, mx = max_iter, ci = iteration whose UPDATE
    // sees conv=1 (0 = never), ab = cycle in which abort is held (0 = none).
    // Cycle c is the clock period that follows edge c-1; start is taken at edge 0.
    task automatic run(input int d, input int mx, input int ci, input int ab);
        int ml, sat, per, k, tmo, uk, a, endc, r, it, ph, n, e, ecnt, etmo, mxc;
        bit finite, cleared, is_upd;
        logic [6:0] ec;
        logic s, cv;
        ml  = (d == 0) ? 1 : 3;
        sat = (d == 0) ? 3 : 255;
        mxc = (d == 0) ? (mx % 4) : mx;
        per = ml + 2;
        if (ci != 0 && (mxc == 0 || ci <= mxc)) begin
            k = ci; tmo = 0; finite = 1;
        end else if (mxc != 0) begin
            k = mxc; tmo = 1; finite = 1;
        end else begin
            k = 1000; tmo = 0; finite = 0;
        end
        uk = 2 + k * per;
        a  = ab;
        if (!finite && a == 0) a = 2 + 8 * per + 1;
        if (a > 2 && (a - 2) % per == 0 && (a - 2) / per <= k) a++;
        if (finite && a > uk + 2) a = 0;
        endc = (a != 0) ? a + 2 : uk + 3;
        ecnt = prev_cnt[d];
        etmo = prev_tmo[d];

        drive(d, 1'b1, 1'b0, 1'b0, mxc);
        @(posedge clk); #1;
        for (int c = 1; c <= endc; c++) begin
            // expected load/busy/done pattern
            if (a != 0 && c > a)  ec = 7'b0000000;
            else if (c == 1)      ec = 7'b1000010;
            else if (c == 2)      ec = 7'b0100010;
            else begin
                r  = c - 3;
                it = r / per;
                ph = r % per;
                if (it < k) begin
                    if (ph < ml)       ec = 7'b0010010;
                    else if (ph == ml) ec = 7'b0001010;
                    else               ec = 7'b0000110;
                end else begin
                    ec = 7'b0000001;
                end
            end
            // expected count: completed updates before this cycle
            cleared = (c >= 3) && (a == 0 || a >= 3);
            e = (a != 0 && c > a) ? a + 1 : c;
            n = (e >= 3) ? (e - 3) / per : 0;
            if (n > k)   n = k;
            if (n > sat) n = sat;
            ecnt = cleared ? n : prev_cnt[d];
            if (a != 0 && c > a)       etmo = 0;
            else if (c < 3)            etmo = prev_tmo[d];
            else if (finite && c > uk) etmo = tmo;
            else                       etmo = 0;

            check($sformatf("d%0d_c%0d_outs", d, c), 32'(get_code(d)), 32'(ec));
            check($sformatf("d%0d_c%0d_cnt", d, c), get_cnt(d), ecnt);
            check($sformatf("d%0d_c%0d_tmo", d, c), get_tmo(d), etmo);

            // inputs held during cycle c, sampled at edge c
            is_upd = (c > 2) && ((c - 2) % per == 0);
            if (c == a)                                  s = 1'b1;
            else if ((a == 0 || c < a) && c <= uk)       s = ($urandom_range(0, 1) == 1);
            else                                         s = 1'b0;
            if (is_upd) cv = ((c - 2) / per == ci);
            else        cv = ($urandom_range(0, 1) == 1);
            if (c == endc) begin
                s = 1'b0; cv = 1'b0;
            end
            drive(d, s, (c == a), cv, mxc);
            @(posedge clk); #1;
        end
        drive(d, 1'b0, 1'b0, 1'b0, mxc);
        prev_cnt[d] = ecnt;
        prev_tmo[d] = etmo;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 1'b0, 0);
        prev_cnt[0] = 0; prev_cnt[1] = 0;
        prev_tmo[0] = 0; prev_tmo[1] = 0;
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_d%0d_outs", d), 32'(get_code(d)), 32'd0);
            check($sformatf("reset_d%0d_cnt", d), get_cnt(d), 0);
            check($sformatf("reset_d%0d_tmo", d), get_tmo(d), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // directed scenarios
        run(0, 0, 1, 0);      // first-update convergence, MULT_LAT=1
        run(1, 4, 0, 0);      // limit of 4 with MULT_LAT=3 -> timeout
        run(0, 2, 2, 0);      // conv and limit together: conv wins
        run(1, 2, 0, 0);      // ends with timeout=1
        run(1, 0, 1, 0);      // restart from FINISH clears timeout at LOAD_INIT
        run(1, 0, 0, 6);      // abort together with start in STORE
        run(0, 0, 0, 0);      // unlimited, ITER_W=2 saturates at 3
        run(1, 3, 0, 2);      // abort in LOAD_INIT keeps previous count

        // randomized runs
        for (int i = 0; i < 40; i++) begin
            int d, mx, ci, ab;
            d  = $urandom_range(0, 1);
            mx = (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 6);
            ci = $urandom_range(0, 5);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run(d, mx, ci, ab);
        end

        // asynchronous reset in the middle of the second MULT phase
        drive(1, 1'b1, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 0);
        repeat (7) @(posedge clk);
        #1;
        check("midmult_outs", 32'(code1), 32'b0010010);
        check("midmult_cnt", int'(cnt1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(code1), 32'd0);
        check("async_rst_cnt", int'(cnt1), 0);
        check("async_rst_tmo", int'(tmo1), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(code1), 32'd0);
        prev_cnt[0] = 0; prev_cnt[1] = 0;
        prev_tmo[0] = 0; prev_tmo[1] = 0;
        run(1, 0, 2, 0);
        run(0, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
